// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types for the 4-lane TDM receive path
package tdm_pkg;
  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } tdm_state_t;
endpackage

// File: rtl/tdm_lane_reg.sv
// rtl/tdm_lane_reg.sv - write-enabled bank of LANES lane words
module tdm_lane_reg
  import tdm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  lane_idx_t                 idx,
  input  logic [W-1:0]              wdata,
  output logic [LANES-1:0][W-1:0]   lanes
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (we && (idx == lane_idx_t'(i))) begin
          lanes[i] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/tdm_demux_4.sv
// rtl/tdm_demux_4.sv - rebuilds four TDM lanes from a serial word stream
// Frames start with a sof-marked lane 0 word; the full frame is held until taken.
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  input  logic         i_sof,
  output logic         o_ready,
  output logic [W-1:0] o_lane0,
  output logic [W-1:0] o_lane1,
  output logic [W-1:0] o_lane2,
  output logic [W-1:0] o_lane3,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_err
);

  tdm_state_t                state;
  tdm_state_t                state_nxt;
  lane_idx_t                 count;
  lane_idx_t                 count_nxt;
  lane_idx_t                 widx;
  logic                      we;
  logic                      err_nxt;
  logic                      accept;
  logic [LANES-1:0][W-1:0]   lanes;

  assign o_ready = (state == COLLECT);
  assign o_valid = (state == HOLD);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= COLLECT;
      count <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      o_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = 1'b0;
    we        = 1'b0;
    widx      = count;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (i_sof) begin
            // sof always restarts a frame; a nonzero count means we resynced
            we        = 1'b1;
            widx      = '0;
            count_nxt = 2'd1;
            err_nxt   = (count != 2'd0);
          end else if (count == 2'd0) begin
            err_nxt = 1'b1;
          end else begin
            we        = 1'b1;
            widx      = count;
            count_nxt = count + 2'd1;
            if (count == 2'd3) begin
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  tdm_lane_reg #(
    .W(W)
  ) u_lane_reg (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (we),
    .idx   (widx),
    .wdata (i_data),
    .lanes (lanes)
  );

  assign o_lane0 = lanes[0];
  assign o_lane1 = lanes[1];
  assign o_lane2 = lanes[2];
  assign o_lane3 = lanes[3];

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb/tb_tdm_demux_4.sv - scoreboard bench for tdm_demux_4
module tb_tdm_demux_4;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_data;
  logic       i_valid;
  logic       i_sof;
  logic       o_ready;
  logic [3:0] o_lane0;
  logic [3:0] o_lane1;
  logic [3:0] o_lane2;
  logic [3:0] o_lane3;
  logic       o_valid;
  logic       i_ready;
  logic       o_err;

  int n_chk;
  int n_fail;
  int exp_err;
  int obs_err;
  logic [15:0] frame_q[$];
  logic [1:0]  tx_cnt;
  logic        prev_hs;
  logic        prev_stall;
  logic [15:0] prev_lanes;
  logic [15:0] cur_lanes;
  logic [15:0] exp_frame;

  tdm_demux_4 #(.W(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .o_ready (o_ready),
    .o_lane0 (o_lane0),
    .o_lane1 (o_lane1),
    .o_lane2 (o_lane2),
    .o_lane3 (o_lane3),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_err   (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign cur_lanes = {o_lane0, o_lane1, o_lane2, o_lane3};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: 4:1 mux selected by a 2-bit counter, sof on slot 0
  function automatic logic [3:0] mux4(input logic [1:0] sel, input logic [15:0] f);
    case (sel)
      2'd0:    mux4 = f[15:12];
      2'd1:    mux4 = f[11:8];
      2'd2:    mux4 = f[7:4];
      default: mux4 = f[3:0];
    endcase
  endfunction

  task automatic tx_frame(input logic [15:0] f);
    for (int i = 0; i < 4; i++) begin
      tx_cnt  = 2'(i);
      i_data  = mux4(tx_cnt, f);
      i_sof   = (tx_cnt == 2'd0);
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] d, input logic s);
    i_data  = d;
    i_sof   = s;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic do_reset(input string name);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk({name, "_valid"}, {15'd0, o_valid}, 16'd0);
    chk({name, "_err"},   {15'd0, o_err},   16'd0);
    chk({name, "_lanes"}, cur_lanes,        16'h0000);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on each frame handshake and checks hold stability
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("ready_vs_valid", {15'd0, o_ready}, {15'd0, ~o_valid});
      if (prev_hs) chk("valid_drop", {15'd0, o_valid}, 16'd0);
      if (prev_stall && o_valid) chk("hold_stable", cur_lanes, prev_lanes);
      if (o_err) obs_err++;
      if (o_valid && i_ready) begin
        if (frame_q.size() == 0) begin
          chk("unexpected_frame", cur_lanes, 16'hxxxx);
        end else begin
          exp_frame = frame_q.pop_front();
          chk("frame", cur_lanes, exp_frame);
        end
      end
      prev_hs    = o_valid && i_ready;
      prev_stall = o_valid && !i_ready;
      prev_lanes = cur_lanes;
    end else begin
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; exp_err = 0; obs_err = 0;
    prev_hs = 1'b0; prev_stall = 1'b0; prev_lanes = '0;
    i_data = '0; i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b1; tx_cnt = '0;
    i_rst_n = 1'b0;

    // T1: reset state
    @(posedge i_clk);
    do_reset("t1_rst");
    idle(1);
    chk("t1_ready", {15'd0, o_ready}, 16'd1);
    chk("t1_valid", {15'd0, o_valid}, 16'd0);
    chk("t1_lanes", cur_lanes, 16'h0000);

    // T2: simple frame, downstream always ready
    i_ready = 1'b1;
    frame_q.push_back(16'h0123);
    tx_frame(16'h0123);
    chk("t2_latency", {15'd0, o_valid}, 16'd1);
    idle(1);
    chk("t2_ready_back", {15'd0, o_ready}, 16'd1);
    chk("t2_valid_low", {15'd0, o_valid}, 16'd0);

    // T3: backpressure; extra words must be refused
    i_ready = 1'b0;
    frame_q.push_back(16'hABCD);
    tx_frame(16'hABCD);
    for (int i = 0; i < 3; i++) begin
      i_data = 4'hF; i_sof = 1'b1; i_valid = 1'b1;
      chk("t3_ready", {15'd0, o_ready}, 16'd0);
      chk("t3_valid", {15'd0, o_valid}, 16'd1);
      chk("t3_lanes", cur_lanes, 16'hABCD);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0; i_sof = 1'b0;
    chk("t3_lanes_after", cur_lanes, 16'hABCD);
    i_ready = 1'b1;
    idle(1);
    chk("t3_valid_low", {15'd0, o_valid}, 16'd0);

    // T4: resync mid-frame
    send_word(4'h5, 1'b1);
    send_word(4'h6, 1'b0);
    send_word(4'h9, 1'b1);
    exp_err++;
    chk("t4_err_pulse", {15'd0, o_err}, 16'd1);
    frame_q.push_back(16'h987E);
    send_word(4'h8, 1'b0);
    chk("t4_err_gone", {15'd0, o_err}, 16'd0);
    send_word(4'h7, 1'b0);
    send_word(4'hE, 1'b0);
    chk("t4_valid", {15'd0, o_valid}, 16'd1);
    idle(2);
    chk("t4_err_count", 16'(obs_err), 16'(exp_err));

    // T5: missing sof after reset
    do_reset("t5_rst");
    send_word(4'h3, 1'b0);
    exp_err++;
    chk("t5_err_pulse", {15'd0, o_err}, 16'd1);
    chk("t5_lanes", cur_lanes, 16'h0000);
    frame_q.push_back(16'h0123);
    tx_frame(16'h0123);
    idle(2);
    chk("t5_err_count", 16'(obs_err), 16'(exp_err));

    // T6: reset mid-frame and in HOLD
    send_word(4'hC, 1'b1);
    send_word(4'hD, 1'b0);
    chk("t6_partial_lane0", {12'd0, o_lane0}, 16'h000C);
    do_reset("t6_rst_mid");
    frame_q.push_back(16'h1234);
    tx_frame(16'h1234);
    idle(1);
    i_ready = 1'b0;
    tx_frame(16'h5678);
    chk("t6_hold_valid", {15'd0, o_valid}, 16'd1);
    do_reset("t6_rst_hold");
    i_ready = 1'b1;
    frame_q.push_back(16'h4321);
    tx_frame(16'h4321);
    idle(3);

    chk("sb_empty", 16'(frame_q.size()), 16'd0);
    chk("err_total", 16'(obs_err), 16'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
